inst_fetch_buf: RTL and testbench

Parametrised fetch stage: generates the PC, issues reads to a synchronous instruction ROM (1-cycle read latency), and buffers returned instructions with their PCs in a DEPTH-entry queue. The queue feeds decode through a valid/ready handshake. Supports backpressure from decode and PC redirect from branch/jump, with flush of the queue and of the in-flight read. Successor to the fixed-width, always-fetching PC+ROM pair: adds width/depth/reset-vector parameters, stall, redirect and buffering.

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch_buf_sync_fifo.sv | 62 ++++++
 rtl/inst_fetch_buf.sv | 100 ++++++++++
 tb/tb_inst_fetch_buf.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: PC increment step, default-width fetch entry, PC alignment helper.
package inst_fetch_pkg;

  localparam int PC_STEP   = 4;
  localparam int PC_MAX    = 64;  // widest PC the alignment helper handles
  localparam int NPC_DEF   = 32;
  localparam int NINST_DEF = 32;

  typedef struct packed {
    logic [NPC_DEF-1:0]   pc;
    logic [NINST_DEF-1:0] inst;
  } fetch_entry_t;

  // Clears the two byte-offset bits so every fetch is word aligned.
  function automatic logic [PC_MAX-1:0] align_pc(input logic [PC_MAX-1:0] pc);
    return pc & ~PC_MAX'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_buf_sync_fifo.sv
// Synchronous FIFO with flush; head entry is visible combinationally.
// Latency: a push is visible on head_dat the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; flush empties in one cycle.
// Ports: clk, rst_n (sync, active-low), flush, push/push_dat, pop,
//        head_dat, count, empty, full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared too so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_buf.sv
// Fetch stage: PC generation, sync ROM reads, DEPTH-entry instruction queue to decode.
// Latency: ROM read issued in cycle N appears on o_inst in N+2; redirect target at R+3.
// Backpressure: issues only while queued + in-flight < DEPTH; i_inst_rdy low stalls fetch.
// Ports: i_clk, i_rst_n (sync, active-low); ROM side o_rom_ce/o_rom_addr/i_rom_inst;
//        redirect i_redir_vld/i_redir_pc; decode side o_inst_vld/o_inst/o_inst_pc/i_inst_rdy.
module inst_fetch_buf
  import inst_fetch_pkg::*;
#(
  parameter int             NPC    = 32,
  parameter int             NINST  = 32,
  parameter int             DEPTH  = 4,
  parameter logic [NPC-1:0] RST_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_rom_ce,
  output logic [NPC-1:0]   o_rom_addr,
  input  logic [NINST-1:0] i_rom_inst,
  input  logic             i_redir_vld,
  input  logic [NPC-1:0]   i_redir_pc,
  output logic             o_inst_vld,
  output logic [NINST-1:0] o_inst,
  output logic [NPC-1:0]   o_inst_pc,
  input  logic             i_inst_rdy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int UW = CW + 1;

  typedef struct packed {
    logic [NPC-1:0]   pc;
    logic [NINST-1:0] inst;
  } entry_t;

  logic [NPC-1:0] pc;
  logic [NPC-1:0] req_pc;    // address of the read currently in flight
  logic           rst_q;
  logic           inflight;
  logic           ce;
  logic           push;
  logic           pop;
  logic           empty;
  logic           full;
  logic [CW-1:0]  count;
  logic [UW-1:0]  used;
  entry_t         push_dat;
  entry_t         head;

  // Credit counts the in-flight read as occupied; a same-cycle pop is not credited.
  assign used     = {1'b0, count} + UW'(inflight);
  assign ce       = ~rst_q & ~i_redir_vld & (used < UW'(DEPTH));

  assign o_rom_ce   = ce;
  assign o_rom_addr = pc;

  // A redirect kills the returning read of the previous cycle.
  assign push     = inflight & ~i_redir_vld & ~full;
  assign push_dat = '{pc: req_pc, inst: i_rom_inst};
  assign pop      = ~empty & i_inst_rdy;

  assign o_inst_vld = ~empty;
  assign o_inst     = head.inst;
  assign o_inst_pc  = head.pc;

  always_ff @(posedge i_clk) begin
    // Holds fetch off for one cycle after reset is released.
    rst_q <= ~i_rst_n;
    if (!i_rst_n) begin
      pc       <= RST_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (i_redir_vld) begin
      pc       <= NPC'(align_pc(PC_MAX'(i_redir_pc)));
      inflight <= 1'b0;
    end else begin
      inflight <= ce;
      if (ce) begin
        pc     <= pc + NPC'(PC_STEP);
        req_pc <= pc;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .flush    (i_redir_vld),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf: a 32-bit PC instance (RST_PC=0x100) and an
// 8-bit PC instance (RST_PC=0xF8) share clock, reset, ready and redirect inputs.
module tb_inst_fetch_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        redir_vld;
  logic [31:0] redir_pc;

  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        inst_vld;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic        rom_ce8;
  logic [7:0]  rom_addr8;
  logic [31:0] rom_inst8;
  logic        inst_vld8;
  logic [31:0] inst8;
  logic [7:0]  inst_pc8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_fetch_buf #(.NPC(32), .NINST(32), .DEPTH(4), .RST_PC(32'h100)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_rom_ce(rom_ce), .o_rom_addr(rom_addr), .i_rom_inst(rom_inst),
    .i_redir_vld(redir_vld), .i_redir_pc(redir_pc),
    .o_inst_vld(inst_vld), .o_inst(inst), .o_inst_pc(inst_pc),
    .i_inst_rdy(rdy)
  );

  inst_fetch_buf #(.NPC(8), .NINST(32), .DEPTH(4), .RST_PC(8'hF8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_rom_ce(rom_ce8), .o_rom_addr(rom_addr8), .i_rom_inst(rom_inst8),
    .i_redir_vld(redir_vld), .i_redir_pc(redir_pc[7:0]),
    .o_inst_vld(inst_vld8), .o_inst(inst8), .o_inst_pc(inst_pc8),
    .i_inst_rdy(rdy)
  );

  // ROM contents: a fixed tag plus the low address bits.
  function automatic logic [31:0] romf(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rom_ce)  rom_inst  <= romf(rom_addr);
    if (rom_ce8) rom_inst8 <= romf({24'h0, rom_addr8});
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, let outputs settle, then check.
  task automatic cyc(input logic rn, input logic r, input logic rv, input logic [31:0] rp);
    @(negedge clk);
    rst_n     = rn;
    rdy       = r;
    redir_vld = rv;
    redir_pc  = rp;
    #1;
  endtask

  task automatic do_reset(input logic r);
    cyc(1'b0, r, 1'b0, 32'h0);
    cyc(1'b0, r, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b0; redir_vld = 1'b0; redir_pc = '0;

    // Reset release with ready high; 8-bit instance checks PC wrap.
    do_reset(1'b1);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("rst_ce", rom_ce, 0);
    chk("rst_vld", inst_vld, 0);
    chk("rst_addr", rom_addr, 32'h100);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_ce8", rom_ce8, 0);
    chk("rst_addr8", rom_addr8, 8'hF8);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t1_c1_ce", rom_ce, 1);
    chk("t1_c1_addr", rom_addr, 32'h100);
    chk("t1_c1_addr8", rom_addr8, 8'hF8);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t1_c2_addr", rom_addr, 32'h104);
    chk("t1_c2_vld", inst_vld, 0);
    chk("t1_c2_addr8", rom_addr8, 8'hFC);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t1_c3_vld", inst_vld, 1);
    chk("t1_c3_pc", inst_pc, 32'h100);
    chk("t1_c3_inst", inst, 32'hC0DE_0100);
    chk("t1_c3_addr8", rom_addr8, 8'h00);
    chk("t1_c3_pc8", inst_pc8, 8'hF8);
    chk("t1_c3_inst8", inst8, 32'hC0DE_00F8);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t1_c4_pc", inst_pc, 32'h104);
    chk("t1_c4_addr8", rom_addr8, 8'h04);
    chk("t1_c4_pc8", inst_pc8, 8'hFC);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t1_c5_pc", inst_pc, 32'h108);
    chk("t1_c5_pc8", inst_pc8, 8'h00);
    chk("t1_c5_inst8", inst8, 32'hC0DE_0000);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t1_c6_pc", inst_pc, 32'h10C);
    chk("t1_c6_pc8", inst_pc8, 8'h04);

    // Ready low from reset: queue fills with exactly DEPTH reads.
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("t2_r1_ce", rom_ce, 0);
    cyc(1'b1, 1'b0, 1'b0, 0); chk("t2_c1_addr", rom_addr, 32'h100); chk("t2_c1_ce", rom_ce, 1);
    cyc(1'b1, 1'b0, 1'b0, 0); chk("t2_c2_addr", rom_addr, 32'h104); chk("t2_c2_ce", rom_ce, 1);
    cyc(1'b1, 1'b0, 1'b0, 0); chk("t2_c3_addr", rom_addr, 32'h108); chk("t2_c3_ce", rom_ce, 1);
    cyc(1'b1, 1'b0, 1'b0, 0); chk("t2_c4_addr", rom_addr, 32'h10C); chk("t2_c4_ce", rom_ce, 1);
    cyc(1'b1, 1'b0, 1'b0, 0); chk("t2_c5_ce", rom_ce, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("t2_c6_ce", rom_ce, 0);
    chk("t2_c6_vld", inst_vld, 1);
    chk("t2_c6_pc", inst_pc, 32'h100);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t2_c7_ce", rom_ce, 0);
    chk("t2_c7_pc", inst_pc, 32'h100);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t2_c8_ce", rom_ce, 1);
    chk("t2_c8_addr", rom_addr, 32'h110);
    chk("t2_c8_pc", inst_pc, 32'h104);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t2_c9_pc", inst_pc, 32'h108);
    chk("t2_c9_addr", rom_addr, 32'h114);
    cyc(1'b1, 1'b1, 1'b0, 0); chk("t2_c10_pc", inst_pc, 32'h10C);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t2_c11_pc", inst_pc, 32'h110);
    chk("t2_c11_inst", inst, 32'hC0DE_0110);
    cyc(1'b1, 1'b1, 1'b0, 0); chk("t2_c12_pc", inst_pc, 32'h114);

    // Redirect with 0x108 in flight and two entries queued.
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("t3_c3_addr", rom_addr, 32'h108);
    cyc(1'b1, 1'b0, 1'b1, 32'h203);
    chk("t3_r_ce", rom_ce, 0);
    chk("t3_r_vld", inst_vld, 1);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t3_r1_vld", inst_vld, 0);
    chk("t3_r1_ce", rom_ce, 1);
    chk("t3_r1_addr", rom_addr, 32'h200);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t3_r2_vld", inst_vld, 0);
    chk("t3_r2_addr", rom_addr, 32'h204);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t3_r3_vld", inst_vld, 1);
    chk("t3_r3_pc", inst_pc, 32'h200);
    chk("t3_r3_inst", inst, 32'hC0DE_0200);
    cyc(1'b1, 1'b1, 1'b0, 0); chk("t3_r4_pc", inst_pc, 32'h204);
    cyc(1'b1, 1'b1, 1'b0, 0); chk("t3_r5_pc", inst_pc, 32'h208);

    // Redirect held three cycles: last target wins, no fetch while held.
    cyc(1'b1, 1'b1, 1'b1, 32'h40); chk("t4_h1_ce", rom_ce, 0);
    cyc(1'b1, 1'b1, 1'b1, 32'h80); chk("t4_h2_ce", rom_ce, 0); chk("t4_h2_vld", inst_vld, 0);
    cyc(1'b1, 1'b1, 1'b1, 32'hC0); chk("t4_h3_ce", rom_ce, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t4_c1_ce", rom_ce, 1);
    chk("t4_c1_addr", rom_addr, 32'hC0);
    chk("t4_c1_vld", inst_vld, 0);
    cyc(1'b1, 1'b1, 1'b0, 0); chk("t4_c2_addr", rom_addr, 32'hC4);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t4_c3_vld", inst_vld, 1);
    chk("t4_c3_pc", inst_pc, 32'hC0);

    // One-cycle reset with a full queue and ready toggling.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0);
    chk("t6_full_vld", inst_vld, 1);
    chk("t6_full_pc", inst_pc, 32'h100);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("t6_a_vld", inst_vld, 0);
    chk("t6_a_ce", rom_ce, 0);
    chk("t6_a_inst", inst, 0);
    chk("t6_a_inst_pc", inst_pc, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t6_b_ce", rom_ce, 1);
    chk("t6_b_addr", rom_addr, 32'h100);
    chk("t6_b_vld", inst_vld, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("t6_c_vld", inst_vld, 0);
    chk("t6_c_addr", rom_addr, 32'h104);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("t6_d_vld", inst_vld, 1);
    chk("t6_d_pc", inst_pc, 32'h100);
    chk("t6_d_inst", inst, 32'hC0DE_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
